// File: rtl/timer_regresivo_bcd.sv
// rtl/timer_regresivo_bcd.sv - BCD hh:mm:ss countdown timer with hold-strobe loads
// Optional feature: define TIMER_AUTORECARGA_EN for automatic reload from the last loaded value.
module timer_regresivo_bcd #(
  parameter logic [7:0] HORA_MAX = 8'h23,
  parameter logic [7:0] SEG_MAX  = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [7:0] dato_in,
  input  logic       hold_seg_timer,
  input  logic       hold_min_timer,
  input  logic       hold_hora_timer,
  input  logic       start,
  input  logic       stop,
  input  logic       ack,
  output logic [7:0] seg_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hora_bcd,
  output logic       activo,
  output logic       fin_timer
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] maxv);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= maxv);
  endfunction

  logic ld_ok, ld_seg, ld_min, ld_hora, any_hold, value_nz;
  assign ld_ok    = (state != RUN);
  assign ld_seg   = ld_ok && !hold_seg_timer  && bcd_ok(dato_in, SEG_MAX);
  assign ld_min   = ld_ok && !hold_min_timer  && bcd_ok(dato_in, SEG_MAX);
  assign ld_hora  = ld_ok && !hold_hora_timer && bcd_ok(dato_in, HORA_MAX);
  assign any_hold = !(hold_seg_timer && hold_min_timer && hold_hora_timer);
  assign value_nz = (seg_bcd != 8'h00) || (min_bcd != 8'h00) || (hora_bcd != 8'h00);

  // One-second BCD decrement with borrow chained seconds -> minutes -> hours
  logic [7:0] seg_dec, min_dec, hora_dec;
  logic       b_seg, b_min, dec_zero;
  always_comb begin
    seg_dec = seg_bcd;
    b_seg   = 1'b0;
    if (seg_bcd[3:0] != 4'd0) begin
      seg_dec[3:0] = seg_bcd[3:0] - 4'd1;
    end else begin
      seg_dec[3:0] = 4'd9;
      if (seg_bcd[7:4] != 4'd0) seg_dec[7:4] = seg_bcd[7:4] - 4'd1;
      else begin
        seg_dec[7:4] = 4'd5;
        b_seg        = 1'b1;
      end
    end
    min_dec = min_bcd;
    b_min   = 1'b0;
    if (b_seg) begin
      if (min_bcd[3:0] != 4'd0) begin
        min_dec[3:0] = min_bcd[3:0] - 4'd1;
      end else begin
        min_dec[3:0] = 4'd9;
        if (min_bcd[7:4] != 4'd0) min_dec[7:4] = min_bcd[7:4] - 4'd1;
        else begin
          min_dec[7:4] = 4'd5;
          b_min        = 1'b1;
        end
      end
    end
    hora_dec = hora_bcd;
    if (b_min) begin
      if (hora_bcd[3:0] != 4'd0) begin
        hora_dec[3:0] = hora_bcd[3:0] - 4'd1;
      end else begin
        hora_dec[3:0] = 4'd9;
        hora_dec[7:4] = hora_bcd[7:4] - 4'd1;
      end
    end
    dec_zero = (seg_dec == 8'h00) && (min_dec == 8'h00) && (hora_dec == 8'h00);
  end

  logic [7:0] rl_seg, rl_min, rl_hora;
  logic       reload;
`ifdef TIMER_AUTORECARGA_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rl_seg  <= 8'h00;
      rl_min  <= 8'h00;
      rl_hora <= 8'h00;
    end else begin
      if (ld_seg)  rl_seg  <= dato_in;
      if (ld_min)  rl_min  <= dato_in;
      if (ld_hora) rl_hora <= dato_in;
    end
  end
  // An all-zero shadow cannot restart, so it falls back to latching DONE
  assign reload = (rl_seg != 8'h00) || (rl_min != 8'h00) || (rl_hora != 8'h00);
`else
  assign rl_seg  = 8'h00;
  assign rl_min  = 8'h00;
  assign rl_hora = 8'h00;
  assign reload  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      seg_bcd   <= 8'h00;
      min_bcd   <= 8'h00;
      hora_bcd  <= 8'h00;
      activo    <= 1'b0;
      fin_timer <= 1'b0;
    end else begin
      if (ld_seg)  seg_bcd  <= dato_in;
      if (ld_min)  min_bcd  <= dato_in;
      if (ld_hora) hora_bcd <= dato_in;
      case (state)
        IDLE: begin
          if (start && !any_hold && value_nz) begin
            state  <= RUN;
            activo <= 1'b1;
          end
        end
        RUN: begin
          fin_timer <= 1'b0;
          if (stop) begin
            state  <= IDLE;
            activo <= 1'b0;
          end else if (tick_1hz) begin
            if (dec_zero && reload) begin
              seg_bcd   <= rl_seg;
              min_bcd   <= rl_min;
              hora_bcd  <= rl_hora;
              fin_timer <= 1'b1;
            end else begin
              seg_bcd  <= seg_dec;
              min_bcd  <= min_dec;
              hora_bcd <= hora_dec;
              if (dec_zero) begin
                state     <= DONE;
                fin_timer <= 1'b1;
                activo    <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          if (ack) begin
            state     <= IDLE;
            fin_timer <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          activo <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_regresivo_bcd.sv
// tb/tb_timer_regresivo_bcd.sv - directed self-checking bench for timer_regresivo_bcd
module tb_timer_regresivo_bcd;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, start, stop, ack;
  logic [7:0] dato_in;
  logic       hold_seg_timer, hold_min_timer, hold_hora_timer;
  logic [7:0] seg_bcd, min_bcd, hora_bcd;
  logic       activo, fin_timer;
  int checks = 0;
  int failures = 0;

  timer_regresivo_bcd dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .dato_in(dato_in),
    .hold_seg_timer(hold_seg_timer), .hold_min_timer(hold_min_timer),
    .hold_hora_timer(hold_hora_timer), .start(start), .stop(stop), .ack(ack),
    .seg_bcd(seg_bcd), .min_bcd(min_bcd), .hora_bcd(hora_bcd),
    .activo(activo), .fin_timer(fin_timer)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick_1hz = 0; start = 0; stop = 0; ack = 0; dato_in = 8'h00;
    hold_seg_timer = 1; hold_min_timer = 1; hold_hora_timer = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  // mask bit0=seg, bit1=min, bit2=hora
  task automatic load(input logic [2:0] mask, input logic [7:0] d);
    dato_in = d;
    hold_seg_timer = ~mask[0]; hold_min_timer = ~mask[1]; hold_hora_timer = ~mask[2];
    step();
    idle_inputs();
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1; step(); tick_1hz = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({hora_bcd, min_bcd, seg_bcd} !== 24'h000000 || activo !== 1'b0 || fin_timer !== 1'b0) begin
      failures++;
      $display("FAIL reset got=%h:%h:%h act=%b fin=%b exp=00:00:00 act=0 fin=0",
               hora_bcd, min_bcd, seg_bcd, activo, fin_timer);
    end
  endtask

  task automatic test_countdown();
    logic [7:0] exp;
    do_reset();
    load(3'b001, 8'h05);
    pulse_start();
    checks++;
    if (activo !== 1'b1) begin failures++; $display("FAIL cd_activo got=%b exp=1", activo); end
    for (int i = 1; i <= 5; i++) begin
      pulse_tick();
      exp = 8'h05 - 8'(i);
      checks++;
      if (seg_bcd !== exp) begin failures++; $display("FAIL cd_seg tick=%0d got=%h exp=%h", i, seg_bcd, exp); end
      checks++;
      if (fin_timer !== (i == 5)) begin failures++; $display("FAIL cd_fin tick=%0d got=%b exp=%b", i, fin_timer, i == 5); end
    end
    checks++;
    if (activo !== 1'b0) begin failures++; $display("FAIL cd_done_activo got=%b exp=0", activo); end
    step();
    checks++;
    if (fin_timer !== 1'b1) begin failures++; $display("FAIL cd_fin_hold got=%b exp=1", fin_timer); end
    ack = 1; step(); ack = 0;
    checks++;
    if (fin_timer !== 1'b0) begin failures++; $display("FAIL cd_ack got=%b exp=0", fin_timer); end
    load(3'b001, 8'h01);
    pulse_start();
    checks++;
    if (activo !== 1'b1) begin failures++; $display("FAIL cd_idle_after_ack got=%b exp=1", activo); end
  endtask

  task automatic test_borrow();
    do_reset();
    load(3'b100, 8'h01);
    load(3'b011, 8'h00);
    pulse_start();
    pulse_tick();
    checks++;
    if ({hora_bcd, min_bcd, seg_bcd} !== 24'h005959 || activo !== 1'b1) begin
      failures++; $display("FAIL borrow_1h got=%h:%h:%h act=%b exp=00:59:59 act=1", hora_bcd, min_bcd, seg_bcd, activo);
    end
    stop = 1; step(); stop = 0;
    load(3'b100, 8'h10);
    load(3'b011, 8'h00);
    pulse_start();
    pulse_tick();
    checks++;
    if ({hora_bcd, min_bcd, seg_bcd} !== 24'h095959) begin
      failures++; $display("FAIL borrow_10h got=%h:%h:%h exp=09:59:59", hora_bcd, min_bcd, seg_bcd);
    end
    pulse_tick();
    checks++;
    if ({hora_bcd, min_bcd, seg_bcd} !== 24'h095958) begin
      failures++; $display("FAIL plain_dec got=%h:%h:%h exp=09:59:58", hora_bcd, min_bcd, seg_bcd);
    end
  endtask

  task automatic test_invalid_loads();
    do_reset();
    load(3'b001, 8'h5A);
    load(3'b001, 8'h60);
    load(3'b100, 8'h24);
    load(3'b010, 8'hA0);
    checks++;
    if ({hora_bcd, min_bcd, seg_bcd} !== 24'h000000) begin
      failures++; $display("FAIL invalid_load got=%h:%h:%h exp=00:00:00", hora_bcd, min_bcd, seg_bcd);
    end
    load(3'b111, 8'h23);
    checks++;
    if ({hora_bcd, min_bcd, seg_bcd} !== 24'h232323) begin
      failures++; $display("FAIL multi_load got=%h:%h:%h exp=23:23:23", hora_bcd, min_bcd, seg_bcd);
    end
    load(3'b011, 8'h59);
    load(3'b100, 8'h30);
    checks++;
    if ({hora_bcd, min_bcd, seg_bcd} !== 24'h235959) begin
      failures++; $display("FAIL max_load got=%h:%h:%h exp=23:59:59", hora_bcd, min_bcd, seg_bcd);
    end
  endtask

  task automatic test_stop_priority();
    do_reset();
    load(3'b001, 8'h10);
    pulse_start();
    load(3'b001, 8'h30);
    checks++;
    if (seg_bcd !== 8'h10) begin failures++; $display("FAIL load_in_run got=%h exp=10", seg_bcd); end
    stop = 1; tick_1hz = 1; start = 1; step(); idle_inputs();
    checks++;
    if (seg_bcd !== 8'h10 || activo !== 1'b0) begin
      failures++; $display("FAIL stop_prio got=%h act=%b exp=10 act=0", seg_bcd, activo);
    end
    pulse_tick();
    checks++;
    if (seg_bcd !== 8'h10) begin failures++; $display("FAIL tick_idle got=%h exp=10", seg_bcd); end
    start = 1; hold_min_timer = 0; dato_in = 8'h00; step(); idle_inputs();
    checks++;
    if (activo !== 1'b0) begin failures++; $display("FAIL start_with_hold got=%b exp=0", activo); end
    pulse_start();
    checks++;
    if (activo !== 1'b1) begin failures++; $display("FAIL resume got=%b exp=1", activo); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load(3'b001, 8'h03);
    pulse_start();
    rst_n = 0; step(); rst_n = 1;
    checks++;
    if ({hora_bcd, min_bcd, seg_bcd} !== 24'h000000 || activo !== 1'b0 || fin_timer !== 1'b0) begin
      failures++; $display("FAIL reset_run got=%h:%h:%h act=%b fin=%b exp=00:00:00 act=0 fin=0",
                           hora_bcd, min_bcd, seg_bcd, activo, fin_timer);
    end
    pulse_start();
    checks++;
    if (activo !== 1'b0) begin failures++; $display("FAIL start_zero got=%b exp=0", activo); end
  endtask

  task automatic test_done_loads();
    do_reset();
    ack = 1; step(); ack = 0;
    load(3'b001, 8'h01);
    pulse_start();
    pulse_tick();
    checks++;
    if (fin_timer !== 1'b1) begin failures++; $display("FAIL done_reach got=%b exp=1", fin_timer); end
    load(3'b001, 8'h02);
    checks++;
    if (seg_bcd !== 8'h02 || fin_timer !== 1'b1) begin
      failures++; $display("FAIL done_load got=%h fin=%b exp=02 fin=1", seg_bcd, fin_timer);
    end
    pulse_start();
    checks++;
    if (activo !== 1'b0) begin failures++; $display("FAIL start_in_done got=%b exp=0", activo); end
    ack = 1; step(); ack = 0;
    pulse_start();
    checks++;
    if (activo !== 1'b1 || fin_timer !== 1'b0) begin
      failures++; $display("FAIL back_to_back got act=%b fin=%b exp act=1 fin=0", activo, fin_timer);
    end
  endtask

  task automatic test_autoreload();
    do_reset();
    load(3'b001, 8'h02);
    pulse_start();
    for (int i = 1; i <= 4; i++) begin
      pulse_tick();
      checks++;
      if (seg_bcd !== ((i % 2) ? 8'h01 : 8'h02) || fin_timer !== (i % 2 == 0) || activo !== 1'b1) begin
        failures++; $display("FAIL autoreload tick=%0d got seg=%h fin=%b act=%b", i, seg_bcd, fin_timer, activo);
      end
    end
    step();
    checks++;
    if (fin_timer !== 1'b0) begin failures++; $display("FAIL autoreload_pulse got=%b exp=0", fin_timer); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    step();
    test_reset();
    test_borrow();
    test_invalid_loads();
    test_stop_priority();
    test_reset_mid_run();
`ifdef TIMER_AUTORECARGA_EN
    test_autoreload();
`else
    test_countdown();
    test_done_loads();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
